// File: rtl/generatore_sequenze_if.sv
// Bus between the sequence generator and its environment.
// Groups the table write port, sequence control, the dav_/rfd handshake
// towards the pulse shaper and the status outputs.
//   master : generator side (drives numero, dav_, busy, done)
//   slave  : environment side (drives table writes, control and rfd)
interface generatore_sequenze_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned REP_W  = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   length;
    logic [REP_W-1:0]  repeats;
    logic              start;
    logic              abort;
    logic              rfd;
    logic [7:0]        numero;
    logic              dav_;
    logic              busy;
    logic              done;

    modport master (
        input  wr_en, wr_addr, wr_data, length, repeats, start, abort, rfd,
        output numero, dav_, busy, done
    );

    modport slave (
        output wr_en, wr_addr, wr_data, length, repeats, start, abort, rfd,
        input  numero, dav_, busy, done
    );
endinterface

// File: rtl/generatore_sequenze.sv
// Pulse-length sequence generator: producer end of the dav_/rfd four-phase
// handshake feeding the pulse shaper.
// A table of DEPTH 8-bit entries is loaded through the write port while idle.
// On start, entries 0..len-1 are sent one per handshake (zero entries are
// skipped), and the whole pass is repeated 'repeats' extra times.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous reset, active-high
//   bus   : generatore_sequenze_if master modport (table write, control,
//           handshake numero/dav_/rfd, status busy/done)
module generatore_sequenze #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned REP_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    generatore_sequenze_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitRdy,
        StWaitAck,
        StAdvance
    } state_e;

    localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OneLen   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [REP_W-1:0]  rep_left_q, rep_left_d;
    logic [7:0]        numero_q, numero_d;
    logic              dav_n_q, dav_n_d;
    logic              done_q, done_d;

    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W:0]   len_eff;
    logic              last_entry;
    logic [7:0]        cur_entry;

    assign len_eff    = (bus.length > DepthLen) ? DepthLen : bus.length;
    assign last_entry = ({1'b0, idx_q} == (len_q - OneLen));
    assign cur_entry  = mem_q[idx_q];

    // Table storage has no reset; writes are only accepted while idle so the
    // running sequence always sees a stable table.
    always_ff @(posedge clock) begin
        if (bus.wr_en && (state_q == StIdle)) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rep_left_d = rep_left_q;
        numero_d   = numero_q;
        dav_n_d    = dav_n_q;
        done_d     = 1'b0;

        if (bus.abort) begin
            // Abort wins over everything, including a start in idle.
            state_d = StIdle;
            dav_n_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    dav_n_d = 1'b1;
                    if (bus.start) begin
                        if (len_eff != '0) begin
                            len_d      = len_eff;
                            rep_left_d = bus.repeats;
                            idx_d      = '0;
                            state_d    = StFetch;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StFetch: begin
                    numero_d = cur_entry;
                    // Zero is not a legal pulse length for the consumer.
                    state_d  = (cur_entry == 8'd0) ? StAdvance : StWaitRdy;
                end
                StWaitRdy: begin
                    if (bus.rfd) begin
                        dav_n_d = 1'b0;
                        state_d = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (!bus.rfd) begin
                        dav_n_d = 1'b1;
                        state_d = StAdvance;
                    end
                end
                StAdvance: begin
                    if (!last_entry) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end else if (rep_left_q != '0) begin
                        rep_left_d = rep_left_q - 1'b1;
                        idx_d      = '0;
                        state_d    = StFetch;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    dav_n_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            len_q      <= '0;
            rep_left_q <= '0;
            numero_q   <= 8'd0;
            dav_n_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            rep_left_q <= rep_left_d;
            numero_q   <= numero_d;
            dav_n_q    <= dav_n_d;
            done_q     <= done_d;
        end
    end

    assign bus.numero = numero_q;
    assign bus.dav_   = dav_n_q;
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_generatore_sequenze.sv
// Self-checking bench for generatore_sequenze: directed scenarios followed by
// randomized table/length/repeat runs, compared against a list of expected
// words built directly from the table contents.
module tb_generatore_sequenze;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    generatore_sequenze_if #(.ADDR_W(4), .REP_W(4)) bus_if ();

    generatore_sequenze #(
        .DEPTH  (16),
        .ADDR_W (4),
        .REP_W  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the following negedge.
    task automatic write_mem(input int a, input logic [7:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a[3:0];
        bus_if.wr_data = d;
        @(negedge clock);
        bus_if.wr_en   = 1'b0;
        model_mem[a]   = d;
    endtask

    task automatic wait_dav_low();
        int k;
        k = 0;
        while (bus_if.dav_ !== 1'b0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("dav_low_reached", bus_if.dav_, 1'b0);
    endtask

    // Starts a sequence and plays the consumer until done (or budget runs out).
    // hold: cycles rfd stays low before the first word; maxdly: random consumer lag.
    task automatic run_seq(input int len, input int reps, input int hold, input int maxdly);
        logic [7:0] expq[$];
        logic [7:0] first_word;
        logic [7:0] held;
        int len_eff;
        int n_words;
        int hold_cnt;
        int cphase;
        int dly;
        int done_cnt;
        int got;
        bit prev_dav;
        bit rfd_edge;
        bit expect_fall;
        bit stall_chk;

        len_eff = (len > DEPTH) ? DEPTH : len;
        for (int r = 0; r <= reps; r++)
            for (int i = 0; i < len_eff; i++)
                if (model_mem[i] != 8'd0) expq.push_back(model_mem[i]);
        n_words    = expq.size();
        first_word = (n_words > 0) ? expq[0] : 8'd0;
        stall_chk  = (hold >= 5) && (len_eff > 0) && (model_mem[0] != 8'd0);

        hold_cnt    = hold;
        cphase      = 0;
        dly         = 0;
        done_cnt    = 0;
        got         = 0;
        held        = 8'd0;
        prev_dav    = 1'b1;
        expect_fall = 1'b0;

        bus_if.length  = len[4:0];
        bus_if.repeats = reps[3:0];
        bus_if.rfd     = (hold == 0);
        bus_if.start   = 1'b1;

        for (int cyc = 0; cyc < 4000 && done_cnt == 0; cyc++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            rfd_edge     = bus_if.rfd;

            if (expect_fall) begin
                check("dav_fall_one_edge_after_rfd", bus_if.dav_, 1'b0);
                expect_fall = 1'b0;
            end
            if (prev_dav && !bus_if.dav_) check("dav_only_with_rfd_high", rfd_edge, 1'b1);
            if (!prev_dav && bus_if.dav_) check("dav_release_after_rfd_low", rfd_edge, 1'b0);
            if (!prev_dav && !bus_if.dav_) check("numero_stable_while_dav", bus_if.numero, held);

            if (bus_if.done) begin
                done_cnt++;
                check("busy_low_at_done", bus_if.busy, 1'b0);
                check("word_count_at_done", got, n_words);
            end

            if (cphase == 0) begin
                if (!bus_if.dav_) begin
                    got++;
                    if (expq.size() == 0) check("word_overrun", got, n_words);
                    else check("word", bus_if.numero, expq.pop_front());
                    held   = bus_if.numero;
                    cphase = 1;
                    dly    = $urandom_range(maxdly, 0);
                end else if (!bus_if.rfd) begin
                    if (hold_cnt > 0) begin
                        hold_cnt--;
                        if (stall_chk && got == 0 && cyc >= 2) begin
                            check("dav_high_while_stalled", bus_if.dav_, 1'b1);
                            check("numero_while_stalled", bus_if.numero, first_word);
                        end
                    end else begin
                        bus_if.rfd = 1'b1;
                        if (stall_chk && got == 0) expect_fall = 1'b1;
                    end
                end
            end else begin
                if (bus_if.rfd) begin
                    if (dly > 0) dly--;
                    else bus_if.rfd = 1'b0;
                end else if (bus_if.dav_) begin
                    cphase   = 0;
                    hold_cnt = $urandom_range(maxdly, 0);
                end
            end
            prev_dav = bus_if.dav_;
        end

        check("done_seen_once", done_cnt, 1);
        check("words_left", expq.size(), 0);
        @(negedge clock);
        check("done_one_cycle", bus_if.done, 1'b0);
        check("idle_after_done", bus_if.busy, 1'b0);
        bus_if.rfd = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.length  = '0;
        bus_if.repeats = '0;
        bus_if.start   = 1'b0;
        bus_if.abort   = 1'b0;
        bus_if.rfd     = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_dav", bus_if.dav_, 1'b1);
        check("reset_numero", bus_if.numero, 8'd0);
        check("reset_busy", bus_if.busy, 1'b0);
        check("reset_done", bus_if.done, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Basic three-word sequence.
        write_mem(0, 8'd3);
        write_mem(1, 8'd5);
        write_mem(2, 8'd2);
        run_seq(3, 0, 0, 2);

        // Zero entry skipped.
        write_mem(0, 8'd4);
        write_mem(1, 8'd0);
        write_mem(2, 8'd7);
        write_mem(3, 8'd1);
        run_seq(4, 0, 0, 1);

        // Repeats.
        write_mem(0, 8'd9);
        write_mem(1, 8'd10);
        run_seq(2, 2, 0, 2);

        // Consumer stalls rfd low for 20 cycles before the first word.
        write_mem(0, 8'h33);
        run_seq(2, 0, 20, 0);

        // Abort in WAIT_ACK, then restart from index 0.
        write_mem(0, 8'd3);
        write_mem(1, 8'd5);
        write_mem(2, 8'd2);
        bus_if.rfd     = 1'b1;
        bus_if.length  = 5'd3;
        bus_if.repeats = 4'd0;
        bus_if.start   = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        wait_dav_low();
        bus_if.abort = 1'b1;
        @(negedge clock);
        bus_if.abort = 1'b0;
        check("abort_dav", bus_if.dav_, 1'b1);
        check("abort_busy", bus_if.busy, 1'b0);
        check("abort_no_done", bus_if.done, 1'b0);
        @(negedge clock);
        check("abort_no_done_later", bus_if.done, 1'b0);
        run_seq(3, 0, 0, 1);

        // Asynchronous reset between edges while dav_ is low.
        bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        wait_dav_low();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_dav", bus_if.dav_, 1'b1);
        check("async_reset_busy", bus_if.busy, 1'b0);
        check("async_reset_numero", bus_if.numero, 8'd0);
        @(negedge clock);
        reset      = 1'b0;
        bus_if.rfd = 1'b1;
        @(negedge clock);

        // Table write while busy is ignored.
        bus_if.rfd     = 1'b0;
        bus_if.length  = 5'd3;
        bus_if.repeats = 4'd0;
        bus_if.start   = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clock);
        check("busy_during_stall", bus_if.busy, 1'b1);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = 4'd0;
        bus_if.wr_data = 8'hEE;
        @(negedge clock);
        bus_if.wr_en = 1'b0;
        bus_if.abort = 1'b1;
        @(negedge clock);
        bus_if.abort = 1'b0;
        bus_if.rfd   = 1'b1;
        run_seq(3, 0, 0, 1);

        // Zero length: immediate done, no handshake.
        run_seq(0, 3, 0, 1);

        // Length above DEPTH is clamped.
        for (int i = 0; i < DEPTH; i++)
            write_mem(i, ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1)));
        run_seq(20, 1, 0, 1);

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 4; w++)
                write_mem($urandom_range(15, 0),
                          ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1)));
            run_seq($urandom_range(20, 0), $urandom_range(2, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
